pll_rst_ctrl: RTL

PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

---
 rtl/pll_rst_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pll_rst_ctrl.sv
// pll_rst_ctrl
// Reset sequencer for a clk_wiz_0 PLL and the CPU it clocks. The PLL is held
// in reset for a fixed pulse. The controller then waits for lock, filters the
// lock indication, and only then releases the CPU reset. While running, a lock
// loss restarts the whole sequence. A soft request resets the CPU only.
//
// Ports
//   i_clk           free-running reference clock (same as clk_wiz_0 clk_in1)
//   i_rst           asynchronous active-high reset
//   i_pll_locked    clk_wiz_0 locked output, asynchronous to i_clk
//   i_soft_rst_req  level request for a CPU-only reset
//   o_pll_reset     clk_wiz_0 reset, active-high, flop output
//   o_sys_rst       CPU reset, active-high, flop output
//   o_state         current FSM state encoding
//   o_relock_cnt    lock losses seen in RUN/SOFT, saturating at 255
//   o_tmo_err       sticky flag, set on any lock timeout
//
// state     | meaning
// ----------+----------------------------------------------------------
// PLL_RST   | pll_reset pulse, PLL_RST_CYC cycles
// WAIT_LOCK | waiting for synchronized lock, LOCK_TMO cycle timeout
// FILTER    | need LOCK_FILT consecutive locked cycles
// RUN       | CPU released
// SOFT      | CPU held in reset for at least SOFT_CYC cycles, PLL untouched

module pll_rst_ctrl #(
  parameter int PLL_RST_CYC = 4,
  parameter int LOCK_FILT   = 8,
  parameter int LOCK_TMO    = 64,
  parameter int SOFT_CYC    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_soft_rst_req,
  output logic       o_pll_reset,
  output logic       o_sys_rst,
  output logic [2:0] o_state,
  output logic [7:0] o_relock_cnt,
  output logic       o_tmo_err
);

  localparam int MAX_AB  = (PLL_RST_CYC > LOCK_FILT) ? PLL_RST_CYC : LOCK_FILT;
  localparam int MAX_CD  = (LOCK_TMO > SOFT_CYC) ? LOCK_TMO : SOFT_CYC;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  // Terminal counts: the counter is 0 in the first cycle of a state, so the
  // Nth cycle in the state sees N-1.
  localparam logic [CW-1:0] TC_PLL  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TC_FILT = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] TC_TMO  = CW'(LOCK_TMO - 1);
  localparam logic [CW-1:0] TC_SOFT = CW'(SOFT_CYC - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RUN       = 3'd3,
    S_SOFT      = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [1:0]      r_sync;
  logic            w_lock_s;
  logic            r_pll_reset;
  logic            r_sys_rst;
  logic [7:0]      r_relock_cnt;
  logic            r_tmo_err;
  logic            w_relock_evt;
  logic            w_tmo_evt;

  assign w_lock_s = r_sync[1];

  always_comb begin
    w_state_nxt  = r_state;
    w_relock_evt = 1'b0;
    w_tmo_evt    = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        // Lock is ignored here; the PLL is being reset.
        if (r_cnt >= TC_PLL) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = S_FILTER;
        end else if (r_cnt >= TC_TMO) begin
          w_state_nxt = S_PLL_RST;
          w_tmo_evt   = 1'b1;
        end
      end
      S_FILTER: begin
        if (!w_lock_s)              w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt >= TC_FILT)  w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Lock loss outranks a soft request in the same cycle.
        if (!w_lock_s) begin
          w_state_nxt  = S_PLL_RST;
          w_relock_evt = 1'b1;
        end else if (i_soft_rst_req) begin
          w_state_nxt = S_SOFT;
        end
      end
      S_SOFT: begin
        if (!w_lock_s) begin
          w_state_nxt  = S_PLL_RST;
          w_relock_evt = 1'b1;
        end else if ((r_cnt >= TC_SOFT) && !i_soft_rst_req) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_PLL_RST;
    endcase
  end

  // One shared counter, cleared on every transition. It saturates so a long
  // soft request cannot wrap it back below the SOFT terminal count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != {CW{1'b1}}) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync       <= 2'b00;
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_pll_reset  <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_relock_cnt <= 8'd0;
      r_tmo_err    <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_pll_locked};
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // Decoded from the next state so both resets change on the same edge
      // as the state register.
      r_pll_reset <= (w_state_nxt == S_PLL_RST);
      r_sys_rst   <= (w_state_nxt != S_RUN);
      if (w_relock_evt && (r_relock_cnt != 8'hFF)) r_relock_cnt <= r_relock_cnt + 8'd1;
      if (w_tmo_evt) r_tmo_err <= 1'b1;
    end
  end

  assign o_pll_reset  = r_pll_reset;
  assign o_sys_rst    = r_sys_rst;
  assign o_state      = r_state;
  assign o_relock_cnt = r_relock_cnt;
  assign o_tmo_err    = r_tmo_err;

endmodule
